// File: rtl/demux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux_pkg                                                    |
// | Description : Shared constants and types for the buffered 1-to-2 stream    |
// |               demultiplexer (buffer depth, occupancy width, branch ids).   |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package demux_pkg;

    // Entries held by each branch buffer.
    localparam int BUF_DEPTH = 2;

    // Occupancy must represent 0, 1 and 2.
    localparam int OCC_W = 2;

    // Branch indices as seen on select_i.
    localparam logic BR0 = 1'b0;
    localparam logic BR1 = 1'b1;

    typedef logic [OCC_W-1:0] occ_t;

endpackage
`default_nettype wire

// File: rtl/skid_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : skid_fifo2                                                   |
// | Description : Two-entry first-in first-out buffer with registered head.    |
// |               Storage is two registers addressed by 1-bit read/write       |
// |               pointers, so the head is always a flop output.               |
// | Ports       : clk_i, rst_i        clock, synchronous active-high reset     |
// |               push_i, data_i      write strobe and write data              |
// |               pop_i               remove the head entry                    |
// |               full_o, empty_o     occupancy flags                          |
// |               head_o              oldest stored entry                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module skid_fifo2
    import demux_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [size-1:0] data_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [size-1:0] head_o
);

    localparam occ_t c_occ_full  = occ_t'(BUF_DEPTH);
    localparam occ_t c_occ_empty = '0;

    logic [size-1:0] r_mem [BUF_DEPTH];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    occ_t            r_occ;

    logic            w_push;
    logic            w_pop;

    // Qualify the strobes locally so a misbehaving parent can never overrun
    // or underrun the pointers.
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i  && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Storage is cleared too so the head reads 0 after reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= c_occ_empty;
        end else begin
            // Only accepted beats are written, so X on an idle input bus
            // never reaches storage.
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + occ_t'(1);
                2'b01:   r_occ <= r_occ - occ_t'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign full_o  = (r_occ == c_occ_full);
    assign empty_o = (r_occ == c_occ_empty);
    assign head_o  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/demux_1to2_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux_1to2_buffered                                          |
// | Description : Buffered 1-to-2 stream demultiplexer. Each accepted input    |
// |               beat is steered by select_i into one of two 2-entry FIFOs,   |
// |               each draining to its own valid/ready consumer.               |
// | Ports       : clk_i, rst_i                  clock, sync active-high reset  |
// |               data_i, valid_i, select_i     producer side                  |
// |               ready_o                       producer backpressure          |
// |               data0_o, valid0_o, ready0_i   branch-0 consumer              |
// |               data1_o, valid1_o, ready1_i   branch-1 consumer              |
// |               cnt0_o, cnt1_o                wrapping delivered-beat counts |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module demux_1to2_buffered
    import demux_pkg::*;
#(
    parameter int size  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [size-1:0]  data_i,
    input  logic             valid_i,
    input  logic             select_i,
    output logic             ready_o,
    output logic [size-1:0]  data0_o,
    output logic             valid0_o,
    input  logic             ready0_i,
    output logic [size-1:0]  data1_o,
    output logic             valid1_o,
    input  logic             ready1_i,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
);

    logic [1:0]       w_full;
    logic [1:0]       w_empty;
    logic             w_accept;
    logic             w_push0;
    logic             w_push1;
    logic             w_pop0;
    logic             w_pop1;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Backpressure looks only at the selected buffer's own fullness, never
    // at the consumer readies. A full buffer that is popping this cycle
    // therefore still refuses input, costing one bubble but keeping
    // ready_o off the downstream ready paths.
    assign ready_o  = !rst_i && !w_full[select_i];
    assign w_accept = valid_i && ready_o;
    assign w_push0  = w_accept && (select_i == BR0);
    assign w_push1  = w_accept && (select_i == BR1);

    assign valid0_o = !w_empty[0];
    assign valid1_o = !w_empty[1];
    assign w_pop0   = valid0_o && ready0_i;
    assign w_pop1   = valid1_o && ready1_i;

    skid_fifo2 #(
        .size    (size)
    ) u_fifo0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push0),
        .data_i  (data_i),
        .pop_i   (w_pop0),
        .full_o  (w_full[0]),
        .empty_o (w_empty[0]),
        .head_o  (data0_o)
    );

    skid_fifo2 #(
        .size    (size)
    ) u_fifo1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push1),
        .data_i  (data_i),
        .pop_i   (w_pop1),
        .full_o  (w_full[1]),
        .empty_o (w_empty[1]),
        .head_o  (data1_o)
    );

    // Delivered-beat counters; natural binary wrap from all-ones to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_pop0) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_pop1) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign cnt0_o = r_cnt0;
    assign cnt1_o = r_cnt1;

endmodule
`default_nettype wire

// File: doc/demux_1to2_buffered.md
# demux_1to2_buffered

Buffered 1-to-2 stream demultiplexer: the routing counterpart of the 2-to-1 select mux. It accepts one beat per cycle from a single valid/ready producer and steers it, by `select_i`, into one of two independent 2-entry output buffers, each draining to its own valid/ready consumer. It sits between pipeline stages wherever a single result stream must be split between two downstream units, such as the write-back and store paths.

## Interface
Parameters:
- `size`, default 32: data width in bits.
- `CNT_W`, default 16: width of the per-branch beat counters.

Ports:
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `data_i`  in  size: input beat.
- `valid_i`  in  1: input beat valid.
- `select_i`  in  1: destination of the current input beat; 0 = branch 0, 1 = branch 1.
- `ready_o`  out  1: the block accepts the input beat this cycle.
- `data0_o`  out  size: head of the branch-0 buffer.
- `valid0_o`  out  1: branch-0 head is valid.
- `ready0_i`  in  1: branch-0 consumer accepts the head.
- `data1_o`  out  size: head of the branch-1 buffer.
- `valid1_o`  out  1: branch-1 head is valid.
- `ready1_i`  in  1: branch-1 consumer accepts the head.
- `cnt0_o`  out  CNT_W: beats delivered on branch 0.
- `cnt1_o`  out  CNT_W: beats delivered on branch 1.

## Operation
- Accept condition: the input beat is accepted when `valid_i && ready_o`. The accepted beat is pushed into the buffer chosen by `select_i`.
- `ready_o = !full[select_i]`, a combinational function of `select_i` and the buffer occupancy only. It never depends on `ready0_i` or `ready1_i`.
- `select_i` and `data_i` are ignored whenever no beat is accepted.
- Each branch buffer holds 2 entries and is first-in, first-out. Occupancy is 0, 1 or 2.
  - full = (occupancy == 2); empty = (occupancy == 0).
  - `validN_o = !empty`; `dataN_o` = the oldest entry.
  - A pop occurs when `validN_o && readyN_i`.
- Occupancy update per branch:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged, and the head advances.
  - Push while full cannot occur, because `ready_o` is low.
- Ordering: beats within one branch leave in acceptance order. The two branches are mutually unordered.
- `cntN_o` increments by 1 on each pop of branch N. It wraps from all-ones to 0.
- Reset (`rst_i` high at a rising edge):
  - Both occupancies clear to 0; `valid0_o` and `valid1_o` go to 0.
  - `data0_o`, `data1_o`, `cnt0_o` and `cnt1_o` go to 0.
  - Any buffered beats are discarded, including when reset arrives mid-transfer.
  - While reset is high, no beat is accepted: `ready_o` is forced to 0. In the first cycle after reset, `ready_o` = 1.
- X on `data_i` must not propagate to the outputs unless that beat was accepted.

## Timing
- Latency: a beat accepted at edge N is visible on `dataN_o` with `validN_o` = 1 after edge N, i.e. one cycle later. No combinational path exists from input to output.
- Throughput: 1 beat per cycle sustained, provided the selected consumer holds `readyN_i` = 1.
- Full buffer:
  - With the consumer stalled, `ready_o` drops after the second accepted beat to that branch.
  - If the consumer pops in the same cycle that `ready_o` is low, acceptance resumes in the next cycle.
  - The cost is a one-cycle bubble. This is deliberate: it keeps `ready_o` free of `readyN_i`.
- A stall on one branch does not block beats selected to the other branch.
- Output-side handshake rules:
  - `dataN_o` is held stable while `validN_o && !readyN_i`.
  - `validN_o` never drops without a pop or a reset.

## Structure
- Shared package `demux_pkg`:
  - `BUF_DEPTH = 2`.
  - Occupancy width constant (2 bits).
  - Branch-index constants `BR0 = 1'b0`, `BR1 = 1'b1`.
- Sub-module `skid_fifo2`: a 2-entry FIFO with push, pop, full, empty and head-data signals.
  - It is instantiated twice, parameterised by `size`.
  - The top level contains only the select decode, `ready_o`, and the two counters.

## Test plan
- Reset, then push 0xA0, 0xA1, 0xA2 with `select_i`=0 and `ready0_i`=1:
  - `data0_o` shows A0, A1, A2 on consecutive cycles, each one cycle after acceptance.
  - `cnt0_o` = 3; `valid1_o` stays 0.
- With `ready1_i`=0, push 0xB0, 0xB1, 0xB2 to branch 1:
  - `ready_o` drops after B1; B2 is held off.
  - Raising `ready1_i` gives: B0 pops, B2 is accepted on the following cycle, and the output order is B0, B1, B2.
- Branch 1 full and stalled, then push 0xC0 with `select_i`=0:
  - `ready_o` = 1 and C0 is accepted.
  - `data0_o` = C0 the next cycle.
- Alternate `select_i` 0/1 every cycle for 8 beats, both readies high:
  - No bubbles occur.
  - Each branch receives its 4 beats in order; `cnt0_o` = `cnt1_o` = 4.
- Both buffers hold 2 entries; assert `rst_i` for one cycle:
  - The next cycle shows `valid0_o` = `valid1_o` = 0, both counters 0, and `ready_o` = 1.
  - A stale beat is never emitted afterwards.
- Preload `cnt0_o` to 0xFFFF by popping 65535 beats, then pop one more: `cnt0_o` = 0x0000.
